// File: rtl/dz_msr_monitor.sv
// DZ-family modem status monitor: synchronises and debounces per-line CO/RI,
// latches W1C change flags and raises a registered modem-change interrupt.
module dz_msr_monitor #(
    parameter int unsigned NCH         = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     dzCO,
    input  logic [NCH-1:0]     dzRI,
    input  logic [2*NCH-1:0]   chgCLR,
    input  logic               chgIE,
    output logic [2*NCH-1:0]   regMSR,
    output logic [2*NCH-1:0]   regCHG,
    output logic               chgINTR
);

    localparam int unsigned W  = 2 * NCH;
    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0][W-1:0] r_sync;
    logic [CW-1:0]                 r_cnt [W];
    logic [W-1:0]                  r_msr;
    logic [W-1:0]                  r_chg;
    logic                          r_intr;

    logic [W-1:0]                  w_raw;
    logic [W-1:0]                  w_sync_out;
    logic [CW-1:0]                 w_cnt_d [W];
    logic [W-1:0]                  w_msr_d;
    logic [W-1:0]                  w_evt;

    assign w_raw      = {dzCO, dzRI};
    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Each bit qualifies independently; the event pulses on the edge the stable bit flips.
    always_comb begin
        w_msr_d = r_msr;
        w_evt   = '0;
        for (int b = 0; b < int'(W); b++) begin
            w_cnt_d[b] = '0;
            if (w_sync_out[b] != r_msr[b]) begin
                if (r_cnt[b] == LastCnt) begin
                    w_msr_d[b] = w_sync_out[b];
                    w_evt[b]   = 1'b1;
                end else begin
                    w_cnt_d[b] = r_cnt[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < int'(W); b++) begin
                r_cnt[b] <= '0;
            end
            r_msr  <= '0;
            r_chg  <= '0;
            r_intr <= 1'b0;
        end else begin
            for (int b = 0; b < int'(W); b++) begin
                r_cnt[b] <= w_cnt_d[b];
            end
            r_msr  <= w_msr_d;
            // A new event on the same edge as its clear keeps the flag set.
            r_chg  <= (r_chg & ~chgCLR) | w_evt;
            r_intr <= chgIE & (|r_chg);
        end
    end

    assign regMSR  = r_msr;
    assign regCHG  = r_chg;
    assign chgINTR = r_intr;

endmodule
